// File: rtl/spi_pixel_rx.sv
// rtl/spi_pixel_rx.sv - SPI slave (mode 0) pixel receiver with address tagging and pixel FIFO.
// Define SPI_PIXEL_RX_RGB565_EN for 2-byte RGB565 pixels (default: 3-byte RGB888).
module spi_pixel_rx #(
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 19,
  parameter int FRAME_PIXELS = 384000
) (
  input  logic              clock_clk,
  input  logic              reset_reset,
  input  logic              iSPI_CLK,
  input  logic              iSPI_CS,
  input  logic              iSPI_MOSI,
  output logic              oSPI_MISO,
  output logic              oPix_valid,
  input  logic              iPix_ready,
  output logic [23:0]       oPix_data,
  output logic [ADDR_W-1:0] oPix_addr,
  output logic              oFrame_done,
  output logic              oOverflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 24 + ADDR_W;
`ifdef SPI_PIXEL_RX_RGB565_EN
  localparam logic [1:0] LAST_BYTE = 2'd1;
  localparam int         ACC_W     = 8;
`else
  localparam logic [1:0] LAST_BYTE = 2'd2;
  localparam int         ACC_W     = 16;
`endif
  localparam logic [PW-1:0]     PTR_ONE   = 1;
  localparam logic [CW-1:0]     CNT_ONE   = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [CW-1:0]     CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;

  logic sclk_meta, sclk_s, sclk_prev;
  logic cs_meta, cs_s, cs_prev;
  logic mosi_meta, mosi_s;

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sclk_meta <= 1'b0; sclk_s <= 1'b0; sclk_prev <= 1'b0;
      cs_meta   <= 1'b0; cs_s   <= 1'b0; cs_prev   <= 1'b0;
      mosi_meta <= 1'b0; mosi_s <= 1'b0;
    end else begin
      sclk_meta <= iSPI_CLK;  sclk_s <= sclk_meta; sclk_prev <= sclk_s;
      cs_meta   <= iSPI_CS;   cs_s   <= cs_meta;   cs_prev   <= cs_s;
      mosi_meta <= iSPI_MOSI; mosi_s <= mosi_meta;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, shifting;
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  // Synchronizers reset to 0, so a CS held low across reset release is not a falling edge.
  assign cs_fall   = cs_prev & ~cs_s;
  assign shifting  = (state_q == SHIFT) & ~cs_s;

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_s)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [2:0]       bit_cnt;
  logic [6:0]       bit_sr;
  logic [1:0]       byte_cnt;
  logic [ACC_W-1:0] acc;
  logic             push_req;
  logic [23:0]      push_data;
  logic [7:0]       new_byte;
  logic [23:0]      pixel_next;

  assign new_byte = {bit_sr, mosi_s};

`ifdef SPI_PIXEL_RX_RGB565_EN
  logic [4:0] r5, b5;
  logic [5:0] g6;
  assign r5 = acc[7:3];
  assign g6 = {acc[2:0], new_byte[7:5]};
  assign b5 = new_byte[4:0];
  assign pixel_next = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
`else
  assign pixel_next = {acc, new_byte};
`endif

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      bit_cnt   <= '0;
      bit_sr    <= '0;
      byte_cnt  <= '0;
      acc       <= '0;
      push_req  <= 1'b0;
      push_data <= '0;
    end else begin
      push_req <= 1'b0;
      if ((state_q == SHIFT) && cs_s) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (shifting && sclk_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        bit_sr  <= new_byte[6:0];
        if (bit_cnt == 3'd7) begin
          acc <= ACC_W'({acc, new_byte});
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt  <= '0;
            push_req  <= 1'b1;
            push_data <= pixel_next;
          end else begin
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
      end
    end
  end

  logic [DW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] addr_q;
  logic              overflow_q, full, pop, push_ok, last_addr;

  assign full      = (count == CNT_FULL);
  assign pop       = oPix_valid & iPix_ready;
  // A full FIFO still takes the pixel when the head leaves in the same cycle.
  assign push_ok   = push_req & (~full | pop);
  assign last_addr = (addr_q == ADDR_LAST);

  assign oPix_valid  = (count != '0);
  assign {oPix_data, oPix_addr} = oPix_valid ? mem[rd_ptr] : '0;
  assign oFrame_done = push_ok & last_addr;
  assign oOverflow   = overflow_q;

  always_ff @(posedge clock_clk) begin
    if (push_ok) mem[wr_ptr] <= {push_data, addr_q};
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      addr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        addr_q <= last_addr ? '0 : addr_q + ADDR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop)      count <= count + CNT_ONE;
      else if (!push_ok && pop) count <= count - CNT_ONE;
      if (push_req && !push_ok) overflow_q <= 1'b1;
    end
  end

  logic [7:0] status_now, status_q;
  logic       miso_q;
  assign status_now = {overflow_q, full, 6'b0};
  assign oSPI_MISO  = miso_q;

  // Status is snapshotted at each byte start; bit_cnt==0 on a falling edge means a new byte begins.
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      status_q <= '0;
      miso_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      if (cs_fall) begin
        status_q <= status_now;
        miso_q   <= status_now[7];
      end else begin
        miso_q <= 1'b0;
      end
    end else if (cs_s) begin
      miso_q <= 1'b0;
    end else if (sclk_fall) begin
      if (bit_cnt == 3'd0) begin
        status_q <= status_now;
        miso_q   <= status_now[7];
      end else begin
        miso_q <= status_q[3'd7 - bit_cnt];
      end
    end
  end

endmodule
